// File: rtl/cache_mem_responder_pkg.sv
// Shared definitions for the cache memory-port blocks: error flag bit
// positions and the width of one queued request entry.
package cache_mem_responder_pkg;

  localparam int ERR_OVERFLOW    = 0;
  localparam int ERR_COLLISION   = 1;
  localparam int ERR_UNSOLICITED = 2;
  localparam int NUM_ERR         = 3;

  // Queue entry is {we, addr, data}
  function automatic int entry_width(input int addrbits, input int databits);
    return 1 + addrbits + databits;
  endfunction

endpackage

// File: rtl/cache_mem_responder_sync_fifo.sv
// Reusable synchronous FIFO with full/empty/count. A push while full is
// accepted only if a pop happens in the same cycle; a pop while empty is ignored.
module cache_mem_responder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // Storage is cleared on reset so the head reads as zero when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for a cache line: queues per-word requests, presents
// them to the external bus with req/ack, limits outstanding reads, returns read
// data in order, and pauses the line before the queue can overflow.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int ADDRBITS     = 32,
  parameter int DATABITS     = 32,
  parameter int FIFODEPTH    = 8,
  parameter int PAUSE_MARGIN = 2,
  parameter int MAXRD        = 4,
  parameter int RDCNTBITS    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] line_addr,
  input  logic [DATABITS-1:0] line_wrdata,
  input  logic                line_rdreq,
  input  logic                line_wrreq,
  output logic [DATABITS-1:0] line_rddata,
  output logic                line_rddata_valid,
  output logic                line_pause,
  output logic [ADDRBITS-1:0] ext_addr,
  output logic [DATABITS-1:0] ext_wrdata,
  output logic                ext_we,
  output logic                ext_req,
  input  logic                ext_ack,
  input  logic [DATABITS-1:0] ext_rddata,
  input  logic                ext_rddata_valid,
  input  logic                err_clear,
  output logic [NUM_ERR-1:0]  err_flags
);
  localparam int EW = entry_width(ADDRBITS, DATABITS);
  localparam int CW = $clog2(FIFODEPTH) + 1;

  logic [EW-1:0]        w_push_entry, w_head;
  logic                 w_push, w_pop, w_push_ok, w_full, w_empty;
  logic                 w_rd_full, w_rd_pop, w_unsol, w_rd_ret, w_overflow;
  logic [CW-1:0]        w_count, w_count_next;
  logic [NUM_ERR-1:0]   w_err_set;
  logic [RDCNTBITS-1:0] r_rd_cnt;
  logic [DATABITS-1:0]  r_rddata;
  logic                 r_rddata_valid, r_pause;
  logic [NUM_ERR-1:0]   r_err;

  // A write wins over a same-cycle read; reads carry zero data
  assign w_push       = line_rdreq | line_wrreq;
  assign w_push_entry = line_wrreq ? {1'b1, line_addr, line_wrdata}
                                   : {1'b0, line_addr, {DATABITS{1'b0}}};

  cache_mem_responder_sync_fifo #(.WIDTH(EW), .DEPTH(FIFODEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign {ext_we, ext_addr, ext_wrdata} = w_head;

  // Head reads are held back while MAXRD reads are already in flight
  assign w_rd_full  = (r_rd_cnt == RDCNTBITS'(MAXRD));
  assign ext_req    = ~w_empty & ~(~ext_we & w_rd_full);
  assign w_pop      = ext_req & ext_ack;
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign w_overflow = w_push & w_full & ~w_pop;
  assign w_rd_pop   = w_pop & ~ext_we;
  // Return data with nothing in flight (and no read issuing now) is dropped
  assign w_unsol    = ext_rddata_valid & (r_rd_cnt == '0) & ~w_rd_pop;
  assign w_rd_ret   = ext_rddata_valid & ~w_unsol;
  assign w_count_next = w_count + CW'(w_push_ok) - CW'(w_pop);

  // Collect this cycle's error events
  always_comb begin
    w_err_set                  = '0;
    w_err_set[ERR_OVERFLOW]    = w_overflow;
    w_err_set[ERR_COLLISION]   = line_rdreq & line_wrreq;
    w_err_set[ERR_UNSOLICITED] = w_unsol;
  end

  // Outstanding-read counter: issue increments, return decrements
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_cnt <= '0;
    else begin
      case ({w_rd_pop, w_rd_ret})
        2'b10:   r_rd_cnt <= r_rd_cnt + 1'b1;
        2'b01:   r_rd_cnt <= r_rd_cnt - 1'b1;
        default: r_rd_cnt <= r_rd_cnt;
      endcase
    end
  end

  // Registered return path to the line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rddata       <= '0;
      r_rddata_valid <= 1'b0;
    end else begin
      r_rddata_valid <= w_rd_ret;
      if (w_rd_ret) r_rddata <= ext_rddata;
    end
  end

  // Pause from next-cycle occupancy so the line's one-cycle lag stays safe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pause <= 1'b0;
    else          r_pause <= (w_count_next >= CW'(FIFODEPTH - PAUSE_MARGIN));
  end

  // Sticky error flags; clear beats a same-cycle set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_err <= '0;
    else if (err_clear) r_err <= '0;
    else                r_err <= r_err | w_err_set;
  end

  assign line_rddata       = r_rddata;
  assign line_rddata_valid = r_rddata_valid;
  assign line_pause        = r_pause;
  assign err_flags         = r_err;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: queue-based reference model, per-cycle
// compare process, directed scenarios and a randomized soak phase.
module tb_cache_mem_responder;
  localparam int AW = 32, DW = 32, DEPTH = 8, MARGIN = 2, MAXRD = 4, RCB = 3;

  logic          clk = 1'b0, reset_n = 1'b1;
  logic [AW-1:0] line_addr = '0;
  logic [DW-1:0] line_wrdata = '0, line_rddata, ext_rddata = '0, ext_wrdata;
  logic          line_rdreq = 1'b0, line_wrreq = 1'b0, line_rddata_valid, line_pause;
  logic [AW-1:0] ext_addr;
  logic          ext_we, ext_req, ext_ack = 1'b0, ext_rddata_valid = 1'b0, err_clear = 1'b0;
  logic [2:0]    err_flags;

  cache_mem_responder #(.ADDRBITS(AW), .DATABITS(DW), .FIFODEPTH(DEPTH),
    .PAUSE_MARGIN(MARGIN), .MAXRD(MAXRD), .RDCNTBITS(RCB)) dut (
    .clk(clk), .reset_n(reset_n), .line_addr(line_addr), .line_wrdata(line_wrdata),
    .line_rdreq(line_rdreq), .line_wrreq(line_wrreq), .line_rddata(line_rddata),
    .line_rddata_valid(line_rddata_valid), .line_pause(line_pause),
    .ext_addr(ext_addr), .ext_wrdata(ext_wrdata), .ext_we(ext_we), .ext_req(ext_req),
    .ext_ack(ext_ack), .ext_rddata(ext_rddata), .ext_rddata_valid(ext_rddata_valid),
    .err_clear(err_clear), .err_flags(err_flags));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } ent_t;
  ent_t          mq[$];     // queued requests, head at index 0
  ent_t          plog[$];   // entries accepted by the external bus
  int            m_rd = 0;  // reads in flight
  logic          m_pause = 1'b0, m_vld = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [2:0]    m_err = '0;

  function automatic bit model_req();
    return mq.size() > 0 && !(!mq[0].we && m_rd == MAXRD);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit pop, prd, unsol;
    logic [2:0] ne;
    if (!reset_n) begin
      mq.delete(); m_rd = 0; m_pause = 0; m_vld = 0; m_rdata = '0; m_err = '0;
    end else begin
      ne    = '0;
      pop   = model_req() && ext_ack;
      prd   = pop && !mq[0].we;
      unsol = ext_rddata_valid && m_rd == 0 && !prd;
      if (line_rdreq && line_wrreq) ne[1] = 1'b1;
      if (unsol) ne[2] = 1'b1;
      if (pop) plog.push_back(mq.pop_front());
      if (line_wrreq || line_rdreq) begin
        if (mq.size() == DEPTH) ne[0] = 1'b1;
        else mq.push_back(line_wrreq ? ent_t'{1'b1, line_addr, line_wrdata}
                                     : ent_t'{1'b0, line_addr, '0});
      end
      m_rd  = m_rd + (prd ? 1 : 0) - ((ext_rddata_valid && !unsol) ? 1 : 0);
      m_vld = ext_rddata_valid && !unsol;
      if (m_vld) m_rdata = ext_rddata;
      m_pause = mq.size() >= DEPTH - MARGIN;
      m_err   = err_clear ? 3'b000 : (m_err | ne);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ext_req", 32'(ext_req), 32'(model_req()));
      if (mq.size() > 0) begin
        chk("ext_we", 32'(ext_we), 32'(mq[0].we));
        chk("ext_addr", ext_addr, mq[0].addr);
        chk("ext_wrdata", ext_wrdata, mq[0].data);
      end
      chk("line_pause", 32'(line_pause), 32'(m_pause));
      chk("line_rddata_valid", 32'(line_rddata_valid), 32'(m_vld));
      if (m_vld) chk("line_rddata", line_rddata, m_rdata);
      chk("err_flags", 32'(err_flags), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(negedge clk); endtask

  task automatic idle();
    line_rdreq = 0; line_wrreq = 0; err_clear = 0; ext_rddata_valid = 0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    idle(); ext_ack = 0;
    #1;
    chk("rst_ext_req", 32'(ext_req), 0);
    chk("rst_ext_we", 32'(ext_we), 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_ext_wrdata", ext_wrdata, 0);
    chk("rst_line_rddata", line_rddata, 0);
    chk("rst_line_vld", 32'(line_rddata_valid), 0);
    chk("rst_line_pause", 32'(line_pause), 0);
    chk("rst_err", 32'(err_flags), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic clear_errs();
    err_clear = 1; tick(); err_clear = 0;
  endtask

  initial begin
    bit prev_pause;
    int sent, cyc, pause_occ;
    logic [DW-1:0] wd [32];

    #1 reset_n = 1'b0;
    tick(); tick();
    chk_on = 1'b1;
    do_reset();

    // Single read to 0x1000, data returned a few cycles after the pop
    ext_ack = 1; line_rdreq = 1; line_addr = 32'h1000; tick();
    idle();
    chk("rd1_req", 32'(ext_req), 1);
    chk("rd1_addr", ext_addr, 32'h1000);
    chk("rd1_we", 32'(ext_we), 0);
    tick();
    chk("rd1_req_drop", 32'(ext_req), 0);
    tick(); tick();
    ext_rddata = 32'hDEADBEEF; ext_rddata_valid = 1; tick();
    ext_rddata_valid = 0;
    chk("rd1_vld", 32'(line_rddata_valid), 1);
    chk("rd1_data", line_rddata, 32'hDEADBEEF);
    tick();
    chk("rd1_vld_off", 32'(line_rddata_valid), 0);
    chk("rd1_err", 32'(err_flags), 0);

    // 32-word write burst, bus stalled 20 cycles, line reacts to pause one cycle late
    plog.delete(); ext_ack = 0; sent = 0; cyc = 0; prev_pause = 0; pause_occ = -1;
    while (plog.size() < 32 && cyc < 300) begin
      ext_ack = (cyc >= 20);
      if (line_pause && pause_occ < 0) pause_occ = mq.size();
      if (sent < 32 && !prev_pause) begin
        line_wrreq = 1; line_addr = 32'h2000 + 32'(4 * sent);
        wd[sent] = $urandom; line_wrdata = wd[sent]; sent++;
      end else line_wrreq = 0;
      prev_pause = line_pause;
      tick(); cyc++;
    end
    idle();
    chk("burst_pops", 32'(plog.size()), 32);
    chk("burst_pause_occ", 32'(pause_occ), 6);
    for (int i = 0; i < 32 && i < plog.size(); i++) begin
      chk("burst_addr", plog[i].addr, 32'h2000 + 32'(4 * i));
      chk("burst_data", plog[i].data, wd[i]);
    end
    chk("burst_ovf", 32'(err_flags[0]), 0);

    // Five reads with returns withheld: only MAXRD issue
    plog.delete(); ext_ack = 1;
    for (int i = 0; i < 5; i++) begin
      line_rdreq = 1; line_addr = 32'h4000 + 32'(4 * i); tick();
    end
    idle();
    repeat (8) tick();
    chk("maxrd_pops", 32'(plog.size()), 4);
    chk("maxrd_held", 32'(ext_req), 0);
    ext_rddata = $urandom; ext_rddata_valid = 1; tick();
    ext_rddata_valid = 0; tick(); tick();
    chk("maxrd_5th", 32'(plog.size()), 5);
    for (int i = 0; i < 4; i++) begin
      ext_rddata = $urandom; ext_rddata_valid = 1; tick();
      ext_rddata_valid = 0; tick();
    end
    chk("maxrd_err", 32'(err_flags), 0);

    // Read/write collision at 0x3000
    plog.delete();
    line_rdreq = 1; line_wrreq = 1; line_addr = 32'h3000; line_wrdata = 32'h12345678; tick();
    idle(); tick(); tick();
    chk("coll_pops", 32'(plog.size()), 1);
    if (plog.size() > 0) begin
      chk("coll_we", 32'(plog[0].we), 1);
      chk("coll_addr", plog[0].addr, 32'h3000);
    end
    chk("coll_err", 32'(err_flags), 3'b010);
    clear_errs(); tick();
    chk("coll_clr", 32'(err_flags), 0);

    // Nine pushes into a stalled bus, then unsolicited read data
    ext_ack = 0;
    for (int i = 0; i < 9; i++) begin
      line_wrreq = 1; line_addr = 32'h5000 + 32'(4 * i); line_wrdata = 32'(i); tick();
    end
    idle(); tick();
    chk("ovf_err", 32'(err_flags), 3'b001);
    chk("ovf_occ", 32'(mq.size()), 8);
    ext_rddata = 32'hBAD0BAD0; ext_rddata_valid = 1; tick();
    ext_rddata_valid = 0;
    chk("unsol_vld", 32'(line_rddata_valid), 0);
    tick();
    chk("unsol_err", 32'(err_flags), 3'b101);
    ext_ack = 1; repeat (10) tick();
    clear_errs();

    // Reset mid-burst: 2 reads in flight, 3 entries queued
    line_rdreq = 1; line_addr = 32'h6000; tick();
    line_addr = 32'h6004; tick();
    idle(); tick(); tick();
    ext_ack = 0;
    for (int i = 0; i < 3; i++) begin
      line_wrreq = 1; line_addr = 32'h7000 + 32'(4 * i); tick();
    end
    idle();
    chk("mid_rd", 32'(m_rd), 2);
    chk("mid_occ", 32'(mq.size()), 3);
    do_reset();
    chk("post_rst_req", 32'(ext_req), 0);
    ext_ack = 1; tick();
    chk("post_rst_empty", 32'(ext_req), 0);
    ext_rddata_valid = 1; tick();
    ext_rddata_valid = 0; tick();
    chk("late_err", 32'(err_flags), 3'b100);
    clear_errs();

    // Randomized soak
    prev_pause = 0;
    for (int c = 0; c < 4000; c++) begin
      bit ign;
      ign = ((c / 250) % 5) == 4;
      line_rdreq = 0; line_wrreq = 0;
      if ((ign || !prev_pause) && $urandom_range(0, 99) < 60) begin
        int k;
        k = $urandom_range(0, 99);
        line_addr = {$urandom_range(0, 65535), 2'b00};
        line_wrdata = $urandom;
        if (k < 3) begin line_rdreq = 1; line_wrreq = 1; end
        else if (k < 50) line_rdreq = 1;
        else line_wrreq = 1;
      end
      ext_ack = $urandom_range(0, 99) < 60;
      ext_rddata = $urandom;
      ext_rddata_valid = (m_rd > 0 && $urandom_range(0, 99) < 40) || $urandom_range(0, 199) == 0;
      err_clear = $urandom_range(0, 99) < 3;
      prev_pause = line_pause;
      if (c % 900 == 899) do_reset();
      else tick();
    end
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
